vram_arbiter: RTL



---
 rtl/vram_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter
// Brief    : Video/CPU arbiter and ISSUE/COMPLETE sequencer for the 32K x 8
//            bitmap video DRAM, with bounded CPU starvation.
// Revision : 1.0 - initial release
// ============================================================================
module vram_arbiter #(
    parameter int MAX_WAIT = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        vid_req,
    input  logic [14:0] vid_addr,
    output logic        vid_ack,
    output logic [7:0]  vid_data,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [14:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic        cpu_ack,
    output logic [7:0]  cpu_dout,
    output logic        ram_we,
    output logic [14:0] ram_addr,
    output logic [7:0]  ram_din,
    input  logic [7:0]  ram_dout
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_COMPLETE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_VID = 1'b0,
        OWN_CPU = 1'b1
    } owner_t;

    localparam logic [3:0] c_max_wait = 4'(MAX_WAIT);

    state_t      state_q, state_d;
    owner_t      owner_q, owner_d;
    logic        is_wr_q, is_wr_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        ram_we_q, ram_we_d;
    logic [14:0] ram_addr_q, ram_addr_d;
    logic [7:0]  ram_din_q, ram_din_d;
    logic [7:0]  vid_data_q, vid_data_d;
    logic [7:0]  cpu_dout_q, cpu_dout_d;

    logic w_vid_ack;
    logic w_cpu_ack;
    logic w_cpu_rd_done;
    logic w_vid_elig;
    logic w_cpu_elig;

    // The requester being acked this cycle is masked from the decision.
    assign w_vid_ack     = (state_q == S_COMPLETE) && (owner_q == OWN_VID);
    assign w_cpu_ack     = (state_q == S_COMPLETE) && (owner_q == OWN_CPU);
    assign w_cpu_rd_done = w_cpu_ack && !is_wr_q;
    assign w_vid_elig    = vid_req && !w_vid_ack;
    assign w_cpu_elig    = cpu_req && !w_cpu_ack;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        is_wr_d    = is_wr_q;
        wait_cnt_d = wait_cnt_q;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        vid_data_d = vid_data_q;
        cpu_dout_d = cpu_dout_q;

        if (w_vid_ack) begin
            vid_data_d = ram_dout;
        end
        if (w_cpu_rd_done) begin
            cpu_dout_d = ram_dout;
        end

        case (state_q)
            S_ISSUE: begin
                state_d = S_COMPLETE;
            end
            default: begin
                if (w_cpu_elig && ((wait_cnt_q >= c_max_wait) || !w_vid_elig)) begin
                    state_d    = S_ISSUE;
                    owner_d    = OWN_CPU;
                    is_wr_d    = cpu_we;
                    ram_we_d   = cpu_we;
                    ram_addr_d = cpu_addr;
                    ram_din_d  = cpu_din;
                    wait_cnt_d = 4'd0;
                end else if (w_vid_elig) begin
                    state_d    = S_ISSUE;
                    owner_d    = OWN_VID;
                    is_wr_d    = 1'b0;
                    ram_addr_d = vid_addr;
                    ram_din_d  = cpu_din;
                    if (w_cpu_elig && (wait_cnt_q != 4'd15)) begin
                        wait_cnt_d = wait_cnt_q + 4'd1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            owner_q    <= OWN_VID;
            is_wr_q    <= 1'b0;
            wait_cnt_q <= 4'd0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= 15'd0;
            ram_din_q  <= 8'd0;
            vid_data_q <= 8'd0;
            cpu_dout_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            is_wr_q    <= is_wr_d;
            wait_cnt_q <= wait_cnt_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            vid_data_q <= vid_data_d;
            cpu_dout_q <= cpu_dout_d;
        end
    end

    // Read data bypasses the holding register so it is visible with the ack.
    assign vid_ack  = w_vid_ack;
    assign cpu_ack  = w_cpu_ack;
    assign vid_data = w_vid_ack ? ram_dout : vid_data_q;
    assign cpu_dout = w_cpu_rd_done ? ram_dout : cpu_dout_q;
    assign ram_we   = ram_we_q;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;

endmodule
`default_nettype wire
